// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, H/V counters and blank/sync/DE strobes.
// NTSC/PAL line sets, scandoubled output and interlaced fields; mode changes apply at frame wrap.
module video_timing_gen #(
  parameter int unsigned H_W      = 10,
  parameter int unsigned V_W      = 10,
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned H_TOTAL  = 638,
  parameter int unsigned H_BS     = 529,
  parameter int unsigned H_SS     = 544,
  parameter int unsigned H_SE     = 590,
  parameter int unsigned NV_TOTAL = 262,
  parameter int unsigned NV_BS    = 240,
  parameter int unsigned NV_SS    = 245,
  parameter int unsigned NV_SE    = 248,
  parameter int unsigned PV_TOTAL = 312,
  parameter int unsigned PV_BS    = 300,
  parameter int unsigned PV_SS    = 304,
  parameter int unsigned PV_SE    = 308
) (
  input  logic           CLK,
  input  logic           RESn,
  input  logic           pal,
  input  logic           scandouble,
  input  logic           interlace,
  output logic           ce_pix,
  output logic [H_W-1:0] HC,
  output logic [V_W-1:0] VC,
  output logic           HBlank,
  output logic           HSync,
  output logic           VBlank,
  output logic           VSync,
  output logic           DE,
  output logic           FIELD,
  output logic           LINE_START,
  output logic           FRAME_START
);

  localparam int unsigned DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST_FULL = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_HALF = DIV_W'(PIX_DIV / 2 - 1);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_BS_C     = H_W'(H_BS);
  localparam logic [H_W-1:0] H_SS_C     = H_W'(H_SS);
  localparam logic [H_W-1:0] H_SE_C     = H_W'(H_SE);
  localparam logic [H_W-1:0] H_SYNC_PRE = H_W'(H_SS - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;
  logic [H_W-1:0]   hc_q, hc_d;
  logic [V_W-1:0]   vc_q, vc_d;
  logic             hblank_q, hblank_d;
  logic             hsync_q, hsync_d;
  logic             vblank_q, vblank_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             field_q, field_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             pal_q, pal_d;
  logic             sd_q, sd_d;
  logic             il_q, il_d;

  logic [DIV_W-1:0] div_last_cur;
  logic [V_W-1:0]   v_tot_base, v_bs_base, v_ss_base, v_se_base;
  logic [V_W-1:0]   v_last, v_bs, v_ss, v_se;
  logic             odd_extra;
  logic             wrap;

  // Effective vertical line values for the mode latched at the last frame wrap
  always_comb begin
    v_tot_base = pal_q ? V_W'(PV_TOTAL) : V_W'(NV_TOTAL);
    v_bs_base  = pal_q ? V_W'(PV_BS)    : V_W'(NV_BS);
    v_ss_base  = pal_q ? V_W'(PV_SS)    : V_W'(NV_SS);
    v_se_base  = pal_q ? V_W'(PV_SE)    : V_W'(NV_SE);
    odd_extra  = il_q & ~sd_q & field_q;
    v_last     = (v_tot_base << sd_q) + V_W'(odd_extra) - V_W'(1);
    v_bs       = v_bs_base << sd_q;
    v_ss       = v_ss_base << sd_q;
    v_se       = v_se_base << sd_q;
    div_last_cur = sd_q ? DIV_LAST_HALF : DIV_LAST_FULL;
  end

  // Next-state: divider, counters, strobes and frame-boundary mode reload
  always_comb begin
    div_d         = (div_q == div_last_cur) ? '0 : div_q + DIV_W'(1);
    hc_d          = hc_q;
    vc_d          = vc_q;
    hblank_d      = hblank_q;
    hsync_d       = hsync_q;
    vblank_d      = vblank_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    field_d       = field_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    pal_d         = pal_q;
    sd_d          = sd_q;
    il_d          = il_q;
    wrap          = 1'b0;

    if (ce_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        if (vc_q == v_last) begin
          vc_d = '0;
          wrap = 1'b1;
        end else begin
          vc_d = vc_q + V_W'(1);
        end
      end else begin
        hc_d = hc_q + H_W'(1);
      end

      // Vertical strobes move only where HC steps onto hsync start
      if (hc_q == H_SYNC_PRE) begin
        if (vc_q == v_ss) begin
          vsync_d = 1'b1;
        end else if (vc_q == v_se) begin
          vsync_d = 1'b0;
        end
        if (vc_q == v_bs) begin
          vblank_d = 1'b1;
        end
      end

      if (wrap) begin
        vblank_d = 1'b0;
        pal_d    = pal;
        sd_d     = scandouble;
        il_d     = interlace;
        field_d  = (interlace & ~scandouble) ? ~field_q : 1'b0;
      end

      hblank_d      = (hc_d >= H_BS_C);
      hsync_d       = (hc_d >= H_SS_C) && (hc_d < H_SE_C);
      de_d          = ~hblank_d & ~vblank_d;
      line_start_d  = (hc_d == '0);
      frame_start_d = (hc_d == '0) && (vc_d == '0);
    end

    // A divider length change at frame wrap must shape the very first pixel of the new frame
    ce_d = (div_d == (sd_d ? DIV_LAST_HALF : DIV_LAST_FULL));
  end

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      div_q         <= '0;
      ce_q          <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      hblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vblank_q      <= 1'b0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      field_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pal_q         <= pal;
      sd_q          <= scandouble;
      il_q          <= interlace;
    end else begin
      div_q         <= div_d;
      ce_q          <= ce_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hblank_q      <= hblank_d;
      hsync_q       <= hsync_d;
      vblank_q      <= vblank_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      field_q       <= field_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pal_q         <= pal_d;
      sd_q          <= sd_d;
      il_q          <= il_d;
    end
  end

  assign ce_pix      = ce_q;
  assign HC          = hc_q;
  assign VC          = vc_q;
  assign HBlank      = hblank_q;
  assign HSync       = hsync_q;
  assign VBlank      = vblank_q;
  assign VSync       = vsync_q;
  assign DE          = de_q;
  assign FIELD       = field_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced raster (20 px/line, 12 NTSC / 15 PAL lines).
// Stimulus pushes hand-computed per-frame expectations; a monitor measures each frame and compares.
module tb_video_timing_gen;

  localparam int unsigned H_W = 10;
  localparam int unsigned V_W = 10;

  logic           clk = 1'b0;
  logic           RESn;
  logic           pal, scandouble, interlace;
  logic           ce_pix;
  logic [H_W-1:0] HC;
  logic [V_W-1:0] VC;
  logic           HBlank, HSync, VBlank, VSync, DE, FIELD, LINE_START, FRAME_START;

  video_timing_gen #(
    .H_W(H_W), .V_W(V_W), .PIX_DIV(2),
    .H_TOTAL(20), .H_BS(14), .H_SS(16), .H_SE(18),
    .NV_TOTAL(12), .NV_BS(8), .NV_SS(9), .NV_SE(11),
    .PV_TOTAL(15), .PV_BS(10), .PV_SS(12), .PV_SE(14)
  ) dut (
    .CLK(clk), .RESn(RESn), .pal(pal), .scandouble(scandouble), .interlace(interlace),
    .ce_pix(ce_pix), .HC(HC), .VC(VC), .HBlank(HBlank), .HSync(HSync),
    .VBlank(VBlank), .VSync(VSync), .DE(DE), .FIELD(FIELD),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lines; int hmax; int clks; int ces; int des; int field;
    int vb_vc; int vb_hc; int vs_on; int vs_hc; int vs_off; int hs_on; int hs_off;
  } rec_t;

  rec_t exp_q[$];
  int   lat_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  function automatic rec_t mk(input int lines, input int ces, input int clks, input int des,
                              input int field, input int vb, input int vs_on, input int vs_off);
    rec_t r;
    r.lines = lines; r.hmax = 19; r.clks = clks; r.ces = ces; r.des = des; r.field = field;
    r.vb_vc = vb; r.vb_hc = 16; r.vs_on = vs_on; r.vs_hc = 16; r.vs_off = vs_off;
    r.hs_on = 16; r.hs_off = 18;
    return r;
  endfunction

  // Hand-computed frames: DE covers lines 0..BS since VBlank rises mid-line at HC=16
  function automatic rec_t exp_ntsc(input int field);
    return mk(12, 240, 480, 14 * 9 * 2, field, 8, 9, 11);
  endfunction
  function automatic rec_t exp_dbl();
    return mk(24, 480, 480, 14 * 17, 0, 16, 18, 22);
  endfunction
  function automatic rec_t exp_pal();
    return mk(15, 300, 600, 14 * 11 * 2, 0, 10, 12, 14);
  endfunction
  function automatic rec_t exp_odd();
    return mk(13, 260, 520, 14 * 9 * 2, 1, 8, 9, 11);
  endfunction

  function automatic rec_t exp_for(input int k);
    case (k)
      2:       return exp_dbl();
      3, 8:    return exp_pal();
      4, 6:    return exp_odd();
      default: return exp_ntsc(0);
    endcase
  endfunction

  // {pal, scandouble, interlace} driven after frame k starts, latched at the next wrap
  function automatic logic [2:0] mode_after(input int k);
    case (k)
      1:       return 3'b010;
      2:       return 3'b100;
      3, 4, 5: return 3'b001;
      7:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------- monitor ----------------
  rec_t acc;
  bit   started = 1'b0;
  bit   counting = 1'b0;
  int   lat = 0;
  bit   prev_resn = 1'b1;
  bit   prev_fs = 1'b0, prev_vb = 1'b0, prev_vs = 1'b0, prev_hs = 1'b0;

  task automatic compare_frame(input rec_t a);
    rec_t e;
    if (exp_q.size() == 0) begin
      timeout("frame_unexpected");
      return;
    end
    e = exp_q.pop_front();
    cmp("lines", a.lines, e.lines);
    cmp("hc_max", a.hmax, e.hmax);
    cmp("frame_clks", a.clks, e.clks);
    cmp("ce_count", a.ces, e.ces);
    cmp("de_clks", a.des, e.des);
    cmp("field", a.field, e.field);
    cmp("vblank_rise_vc", a.vb_vc, e.vb_vc);
    cmp("vblank_rise_hc", a.vb_hc, e.vb_hc);
    cmp("vsync_rise_vc", a.vs_on, e.vs_on);
    cmp("vsync_rise_hc", a.vs_hc, e.vs_hc);
    cmp("vsync_fall_vc", a.vs_off, e.vs_off);
    cmp("hsync_rise_hc", a.hs_on, e.hs_on);
    cmp("hsync_fall_hc", a.hs_off, e.hs_off);
  endtask

  always @(negedge clk) begin
    if (!prev_resn) begin
      cmp("reset_hc", int'(HC), 0);
      cmp("reset_vc", int'(VC), 0);
      cmp("reset_strobes", int'({ce_pix, HBlank, HSync, VBlank, VSync, DE, FIELD, LINE_START, FRAME_START}), 0);
      started  = 1'b0;
      counting = RESn;
      lat      = 0;
    end else begin
      if (counting) begin
        lat++;
        if (HC != '0) begin
          counting = 1'b0;
          if (lat_q.size() == 0) timeout("latency_unexpected");
          else cmp("first_advance_clks", lat, lat_q.pop_front());
        end else if (lat > 64) begin
          counting = 1'b0;
          timeout("first_advance");
        end
      end
      if (FRAME_START && !prev_fs) begin
        if (started) compare_frame(acc);
        started = 1'b1;
        acc = '{0, 0, 0, 0, 0, int'(FIELD), -1, -1, -1, -1, -1, -1, -1};
      end
      if (started) begin
        acc.clks++;
        if (ce_pix) acc.ces++;
        if (DE) acc.des++;
        if (int'(VC) + 1 > acc.lines) acc.lines = int'(VC) + 1;
        if (int'(HC) > acc.hmax) acc.hmax = int'(HC);
        if (VBlank && !prev_vb && acc.vb_vc < 0) begin acc.vb_vc = int'(VC); acc.vb_hc = int'(HC); end
        if (VSync && !prev_vs && acc.vs_on < 0) begin acc.vs_on = int'(VC); acc.vs_hc = int'(HC); end
        if (!VSync && prev_vs && acc.vs_off < 0) acc.vs_off = int'(VC);
        if (HSync && !prev_hs && acc.hs_on < 0) acc.hs_on = int'(HC);
        if (!HSync && prev_hs && acc.hs_off < 0) acc.hs_off = int'(HC);
      end
    end
    prev_fs   = FRAME_START;
    prev_vb   = VBlank;
    prev_vs   = VSync;
    prev_hs   = HSync;
    prev_resn = RESn;
  end

  // ---------------- stimulus ----------------
  task automatic wait_rise();
    bit p;
    bit seen;
    p = FRAME_START;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (FRAME_START && !p) seen = 1'b1;
      p = FRAME_START;
    end
    if (!seen) timeout("frame_start_wait");
  endtask

  task automatic wait_pos(input int v, input int h, input bit use_h);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (int'(VC) == v && (!use_h || int'(HC) == h)) seen = 1'b1;
    end
    if (!seen) timeout("position_wait");
  endtask

  initial begin
    RESn = 1'b0;
    {pal, scandouble, interlace} = 3'b000;
    lat_q.push_back(2);
    repeat (3) @(posedge clk);
    #2 RESn = 1'b1;
    wait_rise();
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back(exp_for(k));
      if (k == 7) wait_pos(5, 0, 1'b0);
      @(posedge clk);
      #2 {pal, scandouble, interlace} = mode_after(k);
      wait_rise();
    end

    wait_pos(5, 7, 1'b1);
    @(posedge clk);
    #2 RESn = 1'b0;
    lat_q.push_back(2);
    @(posedge clk);
    #2 RESn = 1'b1;
    wait_rise();
    exp_q.push_back(exp_ntsc(0));
    wait_rise();
    repeat (4) @(negedge clk);

    cmp("frames_left", exp_q.size(), 0);
    cmp("latency_left", lat_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
